lowx_mem_arbiter: RTL and testbench

Two-port arbiter sharing the single external memory port (lowX bus) between the instruction cache miss path and the data cache miss/writeback path. Each side sees a private request/response channel; the arbiter grants one at a time with round-robin fairness, carries one outstanding transaction, and routes the response to its owner. A watchdog terminates any transaction whose response never arrives. It sits between the icache/dcache lowX sides and the top-level memory interface.

---
 rtl/lowx_mem_arbiter_if.sv | 51 +++++
 rtl/lowx_mem_arbiter.sv | 136 +++++++++++++
 tb/tb_lowx_mem_arbiter.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/lowx_mem_arbiter_if.sv
// Bundle of the icache, dcache and downstream memory channels of the lowX arbiter.
// master = arbiter side, slave = caches + memory environment side.
interface lowx_mem_arbiter_if #(
    parameter int XLEN     = 32,
    parameter int BLK_SIZE = 128
);
    logic                ic_req_valid_i;
    logic [XLEN-1:0]     ic_req_addr_i;
    logic                ic_req_uncached_i;
    logic                ic_req_ready_o;
    logic                ic_res_valid_o;
    logic [BLK_SIZE-1:0] ic_res_data_o;
    logic                ic_res_err_o;

    logic                dc_req_valid_i;
    logic [XLEN-1:0]     dc_req_addr_i;
    logic                dc_req_uncached_i;
    logic                dc_req_rw_i;
    logic [BLK_SIZE-1:0] dc_req_wdata_i;
    logic                dc_req_ready_o;
    logic                dc_res_valid_o;
    logic [BLK_SIZE-1:0] dc_res_data_o;
    logic                dc_res_err_o;

    logic                mem_req_valid_o;
    logic                mem_req_ready_i;
    logic [XLEN-1:0]     mem_req_addr_o;
    logic                mem_req_rw_o;
    logic [BLK_SIZE-1:0] mem_req_wdata_o;
    logic                mem_req_uncached_o;
    logic                mem_res_valid_i;
    logic [BLK_SIZE-1:0] mem_res_data_i;

    modport master (
        input  ic_req_valid_i, ic_req_addr_i, ic_req_uncached_i,
        output ic_req_ready_o, ic_res_valid_o, ic_res_data_o, ic_res_err_o,
        input  dc_req_valid_i, dc_req_addr_i, dc_req_uncached_i, dc_req_rw_i, dc_req_wdata_i,
        output dc_req_ready_o, dc_res_valid_o, dc_res_data_o, dc_res_err_o,
        output mem_req_valid_o, mem_req_addr_o, mem_req_rw_o, mem_req_wdata_o, mem_req_uncached_o,
        input  mem_req_ready_i, mem_res_valid_i, mem_res_data_i
    );

    modport slave (
        output ic_req_valid_i, ic_req_addr_i, ic_req_uncached_i,
        input  ic_req_ready_o, ic_res_valid_o, ic_res_data_o, ic_res_err_o,
        output dc_req_valid_i, dc_req_addr_i, dc_req_uncached_i, dc_req_rw_i, dc_req_wdata_i,
        input  dc_req_ready_o, dc_res_valid_o, dc_res_data_o, dc_res_err_o,
        input  mem_req_valid_o, mem_req_addr_o, mem_req_rw_o, mem_req_wdata_o, mem_req_uncached_o,
        output mem_req_ready_i, mem_res_valid_i, mem_res_data_i
    );
endinterface

// File: rtl/lowx_mem_arbiter.sv
// Round-robin arbiter sharing one lowX memory port between icache and dcache,
// one outstanding transaction, response routed to its owner, watchdog on REQ+WAIT.
module lowx_mem_arbiter #(
    parameter int XLEN     = 32,
    parameter int BLK_SIZE = 128,
    parameter int TIMEOUT  = 1023
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    lowx_mem_arbiter_if.master  bus,
    output logic                busy_o
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;

    state_e              state_q, state_d;
    logic                last_d_q, last_d_d;   // 1: dcache won the previous grant
    logic                owner_q, owner_d;     // 1: dcache owns the transaction
    logic [XLEN-1:0]     addr_q, addr_d;
    logic                rw_q, rw_d;
    logic [BLK_SIZE-1:0] wdata_q, wdata_d;
    logic                unc_q, unc_d;
    logic [BLK_SIZE-1:0] data_q, data_d;
    logic                err_q, err_d;
    logic [CW-1:0]       cnt_q, cnt_d;

    logic grant_ic, grant_dc, ic_rdy, dc_rdy, expired;

    assign grant_ic = bus.ic_req_valid_i & (~bus.dc_req_valid_i | last_d_q);
    assign grant_dc = bus.dc_req_valid_i & ~grant_ic;
    // cnt_q counts completed REQ/WAIT cycles, so this is the TIMEOUT-th one
    assign expired  = (cnt_q == CW'(TIMEOUT - 1));

    always_comb begin
        state_d  = state_q;
        last_d_d = last_d_q;
        owner_d  = owner_q;
        addr_d   = addr_q;
        rw_d     = rw_q;
        wdata_d  = wdata_q;
        unc_d    = unc_q;
        data_d   = data_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        ic_rdy   = 1'b0;
        dc_rdy   = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_ic || grant_dc) begin
                    ic_rdy   = grant_ic;
                    dc_rdy   = grant_dc;
                    owner_d  = grant_dc;
                    last_d_d = grant_dc;
                    addr_d   = grant_dc ? bus.dc_req_addr_i : bus.ic_req_addr_i;
                    rw_d     = grant_dc & bus.dc_req_rw_i;
                    wdata_d  = grant_dc ? bus.dc_req_wdata_i : '0;
                    unc_d    = grant_dc ? bus.dc_req_uncached_i : bus.ic_req_uncached_i;
                    cnt_d    = '0;
                    state_d  = REQ;
                end
            end
            REQ: begin
                if (expired) begin
                    data_d  = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (bus.mem_req_ready_i) state_d = WAIT;
                end
            end
            WAIT: begin
                // a response arriving on the final watchdog cycle still wins
                if (bus.mem_res_valid_i) begin
                    data_d  = bus.mem_res_data_i;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (expired) begin
                    data_d  = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            last_d_q <= 1'b1;
            owner_q  <= 1'b0;
            addr_q   <= '0;
            rw_q     <= 1'b0;
            wdata_q  <= '0;
            unc_q    <= 1'b0;
            data_q   <= '0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            last_d_q <= last_d_d;
            owner_q  <= owner_d;
            addr_q   <= addr_d;
            rw_q     <= rw_d;
            wdata_q  <= wdata_d;
            unc_q    <= unc_d;
            data_q   <= data_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

    // ready is held low while reset is asserted even though state reads IDLE
    assign bus.ic_req_ready_o     = ic_rdy & rst_ni;
    assign bus.dc_req_ready_o     = dc_rdy & rst_ni;

    assign bus.mem_req_valid_o    = (state_q == REQ);
    assign bus.mem_req_addr_o     = addr_q;
    assign bus.mem_req_rw_o       = rw_q;
    assign bus.mem_req_wdata_o    = wdata_q;
    assign bus.mem_req_uncached_o = unc_q;

    assign bus.ic_res_valid_o     = (state_q == RESP) & ~owner_q;
    assign bus.dc_res_valid_o     = (state_q == RESP) &  owner_q;
    assign bus.ic_res_data_o      = data_q;
    assign bus.dc_res_data_o      = data_q;
    assign bus.ic_res_err_o       = err_q;
    assign bus.dc_res_err_o       = err_q;

    assign busy_o                 = (state_q != IDLE);
endmodule

// File: tb/tb_lowx_mem_arbiter.sv
// Bench for lowx_mem_arbiter: directed scenarios with literal expectations, then
// random traffic checked every cycle against a transaction-level model.
module tb_lowx_mem_arbiter;
    localparam int XLEN = 32, BLK = 128, TMO = 8;

    logic clk = 1'b0, rst_n = 1'b0, busy;
    int   n_cmp = 0, n_fail = 0;

    always #5 clk = ~clk;

    lowx_mem_arbiter_if #(.XLEN(XLEN), .BLK_SIZE(BLK)) bus();
    lowx_mem_arbiter #(.XLEN(XLEN), .BLK_SIZE(BLK), .TIMEOUT(TMO)) dut (
        .clk_i(clk), .rst_ni(rst_n), .bus(bus), .busy_o(busy));

    // transaction-level reference state
    bit             m_act, m_own, m_lastd = 1'b1, m_rw, m_unc, m_hs, m_done, m_err;
    bit             acc_ic, acc_dc;
    int             m_n;
    logic [XLEN-1:0] m_addr;
    logic [BLK-1:0]  m_wdata, m_data;

    task automatic chk(input string nm, input logic [BLK-1:0] act, input logic [BLK-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        bit e_ir, e_dr, e_mq;
        acc_ic = 1'b0;
        acc_dc = 1'b0;
        if (!rst_n) begin
            chk("rst ic_ready", bus.ic_req_ready_o, 0);
            chk("rst dc_ready", bus.dc_req_ready_o, 0);
            chk("rst mem_valid", bus.mem_req_valid_o, 0);
            chk("rst res_valid", {bus.ic_res_valid_o, bus.dc_res_valid_o}, 0);
            chk("rst busy", busy, 0);
            m_act = 0; m_lastd = 1; m_hs = 0; m_done = 0; m_n = 0;
        end else begin
            e_ir = !m_act && bus.ic_req_valid_i && (!bus.dc_req_valid_i || m_lastd);
            e_dr = !m_act && bus.dc_req_valid_i && !e_ir;
            e_mq = m_act && !m_hs && !m_done;
            chk("ic_ready", bus.ic_req_ready_o, e_ir);
            chk("dc_ready", bus.dc_req_ready_o, e_dr);
            chk("busy", busy, m_act);
            chk("mem_valid", bus.mem_req_valid_o, e_mq);
            if (e_mq) begin
                chk("mem_addr", bus.mem_req_addr_o, m_addr);
                chk("mem_rw", bus.mem_req_rw_o, m_rw);
                chk("mem_wdata", bus.mem_req_wdata_o, m_wdata);
                chk("mem_unc", bus.mem_req_uncached_o, m_unc);
            end
            chk("ic_res_valid", bus.ic_res_valid_o, m_act && m_done && !m_own);
            chk("dc_res_valid", bus.dc_res_valid_o, m_act && m_done && m_own);
            if (m_act && m_done) begin
                chk("res_data", m_own ? bus.dc_res_data_o : bus.ic_res_data_o, m_data);
                chk("res_err", m_own ? bus.dc_res_err_o : bus.ic_res_err_o, m_err);
            end
            // advance the model by one clock
            if (!m_act) begin
                if (e_ir || e_dr) begin
                    m_act = 1; m_own = e_dr; m_lastd = e_dr; m_hs = 0; m_done = 0; m_n = 0;
                    m_addr  = e_dr ? bus.dc_req_addr_i : bus.ic_req_addr_i;
                    m_rw    = e_dr && bus.dc_req_rw_i;
                    m_wdata = e_dr ? bus.dc_req_wdata_i : '0;
                    m_unc   = e_dr ? bus.dc_req_uncached_i : bus.ic_req_uncached_i;
                    acc_ic = e_ir; acc_dc = e_dr;
                end
            end else if (m_done) begin
                m_act = 0;
            end else begin
                m_n++;
                if (!m_hs) begin
                    if (m_n == TMO) begin m_done = 1; m_err = 1; m_data = '0; end
                    else if (bus.mem_req_ready_i) m_hs = 1;
                end else if (bus.mem_res_valid_i) begin
                    m_done = 1; m_err = 0; m_data = bus.mem_res_data_i;
                end else if (m_n == TMO) begin
                    m_done = 1; m_err = 1; m_data = '0;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic clear_inputs();
        bus.ic_req_valid_i = 0; bus.ic_req_addr_i = '0; bus.ic_req_uncached_i = 0;
        bus.dc_req_valid_i = 0; bus.dc_req_addr_i = '0; bus.dc_req_uncached_i = 0;
        bus.dc_req_rw_i = 0; bus.dc_req_wdata_i = '0;
        bus.mem_req_ready_i = 0; bus.mem_res_valid_i = 0; bus.mem_res_data_i = '0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        bus.ic_req_valid_i = 1; bus.dc_req_valid_i = 1;
        #1;
        chk("reset ic_ready", bus.ic_req_ready_o, 0);
        chk("reset busy", busy, 0);
        chk("reset mem_addr", bus.mem_req_addr_o, 0);
        chk("reset res_data", bus.ic_res_data_o, 0);
        step(); step();
        clear_inputs();
        rst_n = 1;
    endtask

    localparam logic [BLK-1:0] D1 = 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF;
    localparam logic [BLK-1:0] W1 = 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321;

    initial begin
        string ord;
        clear_inputs();
        step();
        do_reset();

        // icache-only read
        bus.ic_req_valid_i = 1; bus.ic_req_addr_i = 32'h8000_0040; #1;
        chk("t1 ic_ready", bus.ic_req_ready_o, 1);
        chk("t1 dc_ready", bus.dc_req_ready_o, 0);
        step(); bus.ic_req_valid_i = 0; #1;
        chk("t1 mem_valid", bus.mem_req_valid_o, 1);
        chk("t1 mem_addr", bus.mem_req_addr_o, 32'h8000_0040);
        chk("t1 mem_rw", bus.mem_req_rw_o, 0);
        bus.mem_req_ready_i = 1;
        step(); bus.mem_req_ready_i = 0; bus.mem_res_valid_i = 1; bus.mem_res_data_i = D1;
        step(); bus.mem_res_valid_i = 0; #1;
        chk("t1 ic_res_valid", bus.ic_res_valid_o, 1);
        chk("t1 ic_res_data", bus.ic_res_data_o, D1);
        chk("t1 ic_res_err", bus.ic_res_err_o, 0);
        chk("t1 dc_res_valid", bus.dc_res_valid_o, 0);
        step(); #1;
        chk("t1 pulse end", bus.ic_res_valid_o, 0);
        chk("t1 idle", busy, 0);

        // simultaneous requesters from reset, fastest memory
        do_reset();
        bus.ic_req_valid_i = 1; bus.dc_req_valid_i = 1;
        bus.mem_req_ready_i = 1; bus.mem_res_valid_i = 1;
        ord = "";
        for (int c = 0; c < 16; c++) begin
            #1;
            if (bus.ic_req_ready_o) ord = {ord, $sformatf("I%0d,", c)};
            if (bus.dc_req_ready_o) ord = {ord, $sformatf("D%0d,", c)};
            step();
        end
        n_cmp++;
        if (ord != "I0,D4,I8,D12,") begin
            n_fail++;
            $display("FAIL t2 grant order: got %s expected I0,D4,I8,D12,", ord);
        end
        clear_inputs();
        do_reset();

        // dcache write held through backpressure
        bus.dc_req_valid_i = 1; bus.dc_req_rw_i = 1; bus.dc_req_addr_i = 32'h8000_1000;
        bus.dc_req_wdata_i = W1; #1;
        chk("t3 dc_ready", bus.dc_req_ready_o, 1);
        step(); bus.dc_req_valid_i = 0;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) bus.mem_req_ready_i = 1;
            #1;
            chk("t3 mem_valid", bus.mem_req_valid_o, 1);
            chk("t3 mem_rw", bus.mem_req_rw_o, 1);
            chk("t3 mem_addr", bus.mem_req_addr_o, 32'h8000_1000);
            chk("t3 mem_wdata", bus.mem_req_wdata_o, W1);
            step();
        end
        bus.mem_req_ready_i = 0; bus.mem_res_valid_i = 1; bus.mem_res_data_i = D1;
        step(); bus.mem_res_valid_i = 0; #1;
        chk("t3 dc_res_valid", bus.dc_res_valid_o, 1);
        chk("t3 ic_res_valid", bus.ic_res_valid_o, 0);
        step();

        // watchdog: no memory handshake at all
        bus.ic_req_valid_i = 1; bus.ic_req_addr_i = 32'h8000_2000; #1;
        chk("t4 ic_ready", bus.ic_req_ready_o, 1);
        step(); bus.ic_req_valid_i = 0;
        for (int i = 1; i <= 12; i++) begin
            bus.mem_res_valid_i = (i == 11);
            #1;
            chk($sformatf("t4 ic_res_valid c%0d", i), bus.ic_res_valid_o, i == 9);
            chk($sformatf("t4 mem_valid c%0d", i), bus.mem_req_valid_o, i <= 8);
            if (i == 9) begin
                chk("t4 err", bus.ic_res_err_o, 1);
                chk("t4 data", bus.ic_res_data_o, 0);
            end
            step();
        end
        bus.mem_res_valid_i = 0;

        // spurious responses in IDLE and REQ
        bus.mem_res_valid_i = 1; #1;
        chk("t5 idle res", {bus.ic_res_valid_o, bus.dc_res_valid_o}, 0);
        step(); #1;
        chk("t5 idle busy", busy, 0);
        bus.mem_res_valid_i = 0; bus.ic_req_valid_i = 1;
        step(); bus.ic_req_valid_i = 0; bus.mem_res_valid_i = 1;
        step(); bus.mem_res_valid_i = 0; #1;
        chk("t5 still req", bus.mem_req_valid_o, 1);
        chk("t5 req res", {bus.ic_res_valid_o, bus.dc_res_valid_o}, 0);
        bus.mem_req_ready_i = 1;
        step(); bus.mem_req_ready_i = 0; bus.mem_res_valid_i = 1; bus.mem_res_data_i = W1;
        step(); bus.mem_res_valid_i = 0; #1;
        chk("t5 res", bus.ic_res_valid_o, 1);
        chk("t5 data", bus.ic_res_data_o, W1);
        step();

        // asynchronous reset during WAIT, icache owned so last grant was I
        bus.ic_req_valid_i = 1;
        step(); bus.ic_req_valid_i = 0; bus.mem_req_ready_i = 1;
        step(); bus.mem_req_ready_i = 0;
        #2 rst_n = 0; #1;
        chk("t6 busy async", busy, 0);
        chk("t6 mem_valid async", bus.mem_req_valid_o, 0);
        chk("t6 res async", {bus.ic_res_valid_o, bus.dc_res_valid_o}, 0);
        step(); bus.ic_req_valid_i = 1; bus.dc_req_valid_i = 1;
        step(); rst_n = 1; #1;
        chk("t6 ic wins tie", bus.ic_req_ready_o, 1);
        chk("t6 dc waits", bus.dc_req_ready_o, 0);
        step(); bus.ic_req_valid_i = 0; bus.mem_req_ready_i = 1;
        step(); bus.mem_req_ready_i = 0; bus.mem_res_valid_i = 1;
        step(); bus.mem_res_valid_i = 0;
        step(); #1;
        chk("t6 dc granted next", bus.dc_req_ready_o, 1);
        step(); bus.dc_req_valid_i = 0;

        // random traffic against the model
        for (int c = 0; c < 4000; c++) begin
            if (!bus.ic_req_valid_i || acc_ic) begin
                bus.ic_req_valid_i    = ($urandom_range(0, 2) != 0);
                bus.ic_req_addr_i     = $urandom;
                bus.ic_req_uncached_i = $urandom_range(0, 1);
            end
            if (!bus.dc_req_valid_i || acc_dc) begin
                bus.dc_req_valid_i    = ($urandom_range(0, 2) != 0);
                bus.dc_req_addr_i     = $urandom;
                bus.dc_req_uncached_i = $urandom_range(0, 1);
                bus.dc_req_rw_i       = $urandom_range(0, 1);
                bus.dc_req_wdata_i    = {$urandom, $urandom, $urandom, $urandom};
            end
            bus.mem_req_ready_i = $urandom_range(0, 1);
            bus.mem_res_valid_i = ($urandom_range(0, 4) == 0);
            bus.mem_res_data_i  = {$urandom, $urandom, $urandom, $urandom};
            step();
        end
        clear_inputs();
        repeat (12) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
